// File: rtl/product_acc_pkg.sv
// Shared types and sizing helpers for the product accumulator.
// The optional clamp-on-overflow behaviour is selected with PRODUCT_ACC_SATURATE_EN
// (see acc_add_sat).
package product_acc_pkg;

  // ACCUM collects products, HOLD presents the batch sum downstream
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  // Default batch length and the counter width that goes with it
  localparam int COUNT_DEFAULT = 4;
  localparam int CNT_W_DEFAULT = $clog2(COUNT_DEFAULT + 1);

  // Counter width for an arbitrary batch length
  function automatic int cnt_width(input int count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/acc_add_sat.sv
// Combinational accumulator adder with carry-out.
// With PRODUCT_ACC_SATURATE_EN defined the sum clamps to all-ones on a carry;
// otherwise it wraps modulo 2^ACC_W. The carry is reported either way.
module acc_add_sat #(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [ACC_W-1:0] i_b,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_carry
);

  logic [ACC_W:0] w_raw;

  assign w_raw   = {1'b0, i_a} + {1'b0, i_b};
  assign o_carry = w_raw[ACC_W];

`ifdef PRODUCT_ACC_SATURATE_EN
  // Once clamped, further additions carry again and re-clamp, so the sum stays all-ones
  assign o_sum = w_raw[ACC_W] ? {ACC_W{1'b1}} : w_raw[ACC_W-1:0];
`else
  assign o_sum = w_raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Batch accumulator sitting behind the 3x3 multiplier: sums COUNT products
// ({in_cout, in_product}, zero-extended) and hands the sum downstream with an
// overflow flag. Saturation instead of wrap is enabled by PRODUCT_ACC_SATURATE_EN.
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int PROD_W = 6,
  parameter int ACC_W  = 12,
  parameter int COUNT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_overflow
);

  localparam int CNT_W = cnt_width(COUNT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  acc_state_e       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic [ACC_W-1:0] w_operand;
  logic [ACC_W-1:0] w_sum;
  logic             w_carry;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_in_fire;
  logic             w_out_fire;

  // Handshake qualifiers depend only on state and clr; clr masks both sides
  // so neither a product nor a pending sum can be exchanged while clearing
  assign w_in_ready  = (r_state == ACCUM) && !clr;
  assign w_out_valid = (r_state == HOLD) && !clr;
  assign w_in_fire   = w_in_ready && in_valid;
  assign w_out_fire  = w_out_valid && out_ready;

  // Zero-extend the multiplier result (cout is the top operand bit)
  always_comb begin
    w_operand             = '0;
    w_operand[PROD_W:0]   = {in_cout, in_product};
  end

  acc_add_sat #(
    .ACC_W(ACC_W)
  ) u_add (
    .i_a    (r_acc),
    .i_b    (w_operand),
    .o_sum  (w_sum),
    .o_carry(w_carry)
  );

  // Batch FSM: accumulate COUNT products, then hold the sum until it is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_in_fire) begin
            r_acc <= w_sum;
            r_ovf <= r_ovf | w_carry;
            if (r_cnt == LAST_CNT) begin
              r_cnt   <= '0;
              r_state <= HOLD;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (w_out_fire) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_state <= ACCUM;
          end
        end
        default: begin
          r_state <= ACCUM;
        end
      endcase
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = w_out_valid;
  assign out_sum      = w_out_valid ? r_acc : '0;
  assign out_overflow = w_out_valid & r_ovf;

endmodule
